// File: rtl/lae_pkg.sv
// lae_pkg: shared types and round-constant helpers for the LAE sequencer.
package lae_pkg;
    typedef enum logic [2:0] {IDLE, INIT, STREAM, FIN, TAG} state_e;
    localparam int RCON_W = 5;
    localparam logic [RCON_W-1:0] RCON_SEED = 5'h01;
    function automatic logic [RCON_W-1:0] lfsr_next(input logic [RCON_W-1:0] r);
        return {r[3:0], r[4] ^ r[2]};
    endfunction
endpackage

// File: rtl/lae_rcon_lfsr.sv
// lae_rcon_lfsr: round-constant LFSR, reseeded at session start and stepped once per completed round.
module lae_rcon_lfsr
    import lae_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_i,
    input  logic              adv_i,
    output logic [RCON_W-1:0] rcon_o
);
    logic [RCON_W-1:0] rcon_q, rcon_d;
    always_comb rcon_d = seed_i ? RCON_SEED : adv_i ? lfsr_next(rcon_q) : rcon_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rcon_q <= RCON_SEED;
        else rcon_q <= rcon_d;
    end
    assign rcon_o = rcon_q;
endmodule

// File: rtl/lae_seq_ts.sv
// lae_seq_ts: valid/ready sequencer for the shared LAE round datapath.
// Owns the session FSM, round timing, rcon and a per-share output register; shares are never combined.
module lae_seq_ts
    import lae_pkg::*;
#(
    parameter int NSHARE       = 4,
    parameter int WORD         = 10,
    parameter int INIT_ROUNDS  = 16,
    parameter int FINAL_ROUNDS = 16,
    parameter int RND_LAT      = 1,
    parameter int TAG_WORDS    = 8,
    localparam int DW          = NSHARE * WORD,
    localparam int SEL_W       = TAG_WORDS > 1 ? $clog2(TAG_WORDS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DW-1:0]     in_data_i,
    input  logic              in_ad_i,
    input  logic              in_last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DW-1:0]     out_data_o,
    output logic              out_tag_o,
    output logic              out_last_o,
    output logic              dp_load_o,
    output logic              dp_absorb_o,
    output logic              dp_encrypt_o,
    output logic              dp_round_o,
    output logic [RCON_W-1:0] dp_rcon_o,
    output logic [DW-1:0]     dp_din_o,
    input  logic [DW-1:0]     dp_cout_i,
    output logic [SEL_W-1:0]  dp_tag_sel_o,
    input  logic [DW-1:0]     dp_tag_i,
    output logic              busy_o,
    output logic              done_o
);
    localparam int LAT_W  = RND_LAT > 1 ? $clog2(RND_LAT) : 1;
    localparam int CNT_W  = $clog2((INIT_ROUNDS > FINAL_ROUNDS ? INIT_ROUNDS : FINAL_ROUNDS) + 1);
    localparam int TAG_CW = $clog2(TAG_WORDS + 1);

    state_e            state_q, state_d;
    logic              rnd_pend_q, rnd_pend_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [CNT_W-1:0]  rounds_q, rounds_d;
    logic              enc_pend_q, last_q;
    logic [TAG_CW-1:0] tag_cnt_q;
    logic              out_valid_q, out_tag_q, out_last_q;
    logic [WORD-1:0]   out_q [NSHARE];
    logic              round_end, last_rnd, out_free, accept, tag_ld, fin_go;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = INIT;
            INIT:    if (last_rnd) state_d = STREAM;
            STREAM:  if (last_rnd && last_q) state_d = FIN;
            FIN:     if (last_rnd) state_d = TAG;
            TAG:     if (done_o) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_free     = !out_valid_q || out_ready_i;
        in_ready_o   = state_q == STREAM && !rnd_pend_q && !enc_pend_q && (in_ad_i || out_free);
        accept       = in_valid_i && in_ready_o;
        dp_absorb_o  = accept && in_ad_i;
        dp_encrypt_o = accept && !in_ad_i;
        dp_load_o    = state_q == IDLE && start_i;
        dp_round_o   = rnd_pend_q && lat_q == '0;
        dp_din_o     = in_data_i;
        dp_tag_sel_o = tag_cnt_q[SEL_W-1:0];
        fin_go       = state_q == FIN && !rnd_pend_q && !out_valid_q;
        tag_ld       = state_q == TAG && tag_cnt_q != TAG_CW'(TAG_WORDS) && out_free;
        done_o       = state_q == TAG && out_valid_q && out_ready_i && out_last_q;
        busy_o       = state_q != IDLE;
        out_valid_o  = out_valid_q;
        out_tag_o    = out_valid_q && out_tag_q;
        out_last_o   = out_valid_q && out_last_q;
    end

    // A round is issued the cycle after load/absorb/capture, so ciphertext is captured before the state moves on.
    always_comb begin
        round_end  = rnd_pend_q && lat_q == LAT_W'(RND_LAT - 1);
        last_rnd   = round_end && rounds_q == CNT_W'(1);
        lat_d      = rnd_pend_q && !round_end ? lat_q + 1'b1 : '0;
        rnd_pend_d = dp_load_o || fin_go || dp_absorb_o || enc_pend_q || (rnd_pend_q && !last_rnd);
        rounds_d   = dp_load_o ? CNT_W'(INIT_ROUNDS) :
                     fin_go ? CNT_W'(FINAL_ROUNDS) :
                     (dp_absorb_o || enc_pend_q) ? CNT_W'(1) :
                     round_end ? rounds_q - 1'b1 : rounds_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_pend_q  <= 1'b0;
            lat_q       <= '0;
            rounds_q    <= '0;
            enc_pend_q  <= 1'b0;
            last_q      <= 1'b0;
            tag_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_tag_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            rnd_pend_q  <= rnd_pend_d;
            lat_q       <= lat_d;
            rounds_q    <= rounds_d;
            enc_pend_q  <= dp_encrypt_o;
            last_q      <= dp_load_o ? 1'b0 : (accept && in_last_i) ? 1'b1 : last_q;
            tag_cnt_q   <= dp_load_o ? '0 : tag_ld ? tag_cnt_q + 1'b1 : tag_cnt_q;
            out_valid_q <= (enc_pend_q || tag_ld) ? 1'b1 : (out_valid_q && out_ready_i) ? 1'b0 : out_valid_q;
            out_tag_q   <= tag_ld ? 1'b1 : enc_pend_q ? 1'b0 : out_tag_q;
            out_last_q  <= tag_ld ? tag_cnt_q == TAG_CW'(TAG_WORDS - 1) : enc_pend_q ? 1'b0 : out_last_q;
        end
    end

    for (genvar s = 0; s < NSHARE; s++) begin : g_share
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) out_q[s] <= '0;
            else if (enc_pend_q) out_q[s] <= dp_cout_i[s*WORD +: WORD];
            else if (tag_ld) out_q[s] <= dp_tag_i[s*WORD +: WORD];
        end
        assign out_data_o[s*WORD +: WORD] = out_q[s];
    end

    lae_rcon_lfsr u_rcon (
        .clk    (clk),
        .rst_n  (rst_n),
        .seed_i (dp_load_o),
        .adv_i  (round_end),
        .rcon_o (dp_rcon_o)
    );
endmodule
